// File: rtl/control_fsm_if.sv
// Control bundle between control_fsm and the KGP-miniRISC data_path.
// The controller takes the master side; the data_path (or a bench) takes the slave side.
interface control_fsm_if #(
   parameter int ALU_OP_W = 4,
   parameter int BR_OP_W  = 5
);
   logic [5:0]          opcode;
   logic [5:0]          func;
   logic                ir_write;
   logic                pc_write;
   logic [1:0]          reg_write;
   logic                imm_mux_ctrl;
   logic                alu_mux_ctrl;
   logic [ALU_OP_W-1:0] alu_op;
   logic                dmem_enable;
   logic                dmem_write_enable;
   logic [1:0]          reg_write_mux_ctrl;
   logic [BR_OP_W-1:0]  br_op;
   logic                halted;

   modport master (
      input  opcode, func,
      output ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
             dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, halted
   );

   modport slave (
      output opcode, func,
      input  ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
             dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, halted
   );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the KGP-miniRISC data_path.
// Every output is a register loaded from the next state, so strobes are glitch-free.
module control_fsm #(
   parameter int ALU_OP_W = 4,
   parameter int BR_OP_W  = 5
) (
   input logic           clk,
   input logic           rst,
   control_fsm_if.master bus
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b000001;
   localparam logic [5:0] OP_LW   = 6'b000010;
   localparam logic [5:0] OP_SW   = 6'b000011;
   localparam logic [5:0] OP_BR   = 6'b000100;
   localparam logic [5:0] OP_JAL  = 6'b000101;

   state_t              state_q, state_d;
   logic [5:0]          op_q, op_d, func_q, func_d;
   logic                ir_write_q, ir_write_d, pc_write_q, pc_write_d;
   logic [1:0]          reg_write_q, reg_write_d, rwmux_q, rwmux_d;
   logic                imm_mux_q, imm_mux_d, alu_mux_q, alu_mux_d;
   logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
   logic                dmem_en_q, dmem_en_d, dmem_we_q, dmem_we_d;
   logic [BR_OP_W-1:0]  br_op_q, br_op_d;
   logic                halted_q, halted_d;

   logic                legal, in_instr;
   logic [ALU_OP_W-1:0] dec_alu_op;
   logic                dec_alu_mux, dec_imm_mux;
   logic [1:0]          dec_reg_write, dec_rwmux;

   always_comb begin
      op_d   = op_q;
      func_d = func_q;
      if (state_q == DECODE) begin
         op_d   = bus.opcode;
         func_d = bus.func;
      end

      legal         = 1'b1;
      dec_alu_op    = '0;
      dec_alu_mux   = 1'b0;
      dec_imm_mux   = 1'b0;
      dec_reg_write = 2'b00;
      dec_rwmux     = 2'b00;
      unique case (op_d)
         OP_R: begin
            legal         = (func_d <= 6'd9);
            dec_alu_op    = ALU_OP_W'(func_d[3:0]);
            dec_reg_write = 2'b01;
            dec_rwmux     = 2'b10;
         end
         OP_ADDI: begin
            {dec_alu_mux, dec_imm_mux} = 2'b11;
            dec_reg_write = 2'b01;
            dec_rwmux     = 2'b10;
         end
         OP_LW: begin
            {dec_alu_mux, dec_imm_mux} = 2'b11;
            dec_reg_write = 2'b10;
            dec_rwmux     = 2'b01;
         end
         OP_SW:   {dec_alu_mux, dec_imm_mux} = 2'b11;
         OP_BR:   dec_alu_op = ALU_OP_W'(1);
         OP_JAL:  dec_reg_write = 2'b11;
         default: legal = 1'b0;
      endcase

      // A FETCH with ir_write still low is the idle cycle right after reset.
      state_d = state_q;
      unique case (state_q)
         FETCH:   state_d = ir_write_q ? DECODE : FETCH;
         DECODE:  state_d = legal ? EXEC : HALT;
         EXEC:    state_d = (op_d == OP_BR) ? FETCH :
                            (op_d == OP_LW || op_d == OP_SW) ? MEM : WB;
         MEM:     state_d = (op_d == OP_LW) ? WB : FETCH;
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase

      in_instr    = (state_d == EXEC) || (state_d == MEM) || (state_d == WB);
      ir_write_d  = (state_d == FETCH);
      alu_op_d    = in_instr ? dec_alu_op : '0;
      alu_mux_d   = in_instr && dec_alu_mux;
      imm_mux_d   = in_instr && dec_imm_mux;
      dmem_en_d   = (state_d == MEM);
      dmem_we_d   = (state_d == MEM) && (op_d == OP_SW);
      reg_write_d = (state_d == WB) ? dec_reg_write : 2'b00;
      rwmux_d     = (state_d == WB) ? dec_rwmux : 2'b00;
      halted_d    = (state_d == HALT);
      pc_write_d  = (state_d == WB) ||
                    ((state_d == MEM) && (op_d == OP_SW)) ||
                    ((state_d == EXEC) && (op_d == OP_BR));

      br_op_d = '0;
      if ((state_d == EXEC) && (op_d == OP_BR))
         br_op_d = BR_OP_W'(func_d[4:0]);
      else if (((state_d == EXEC) || (state_d == WB)) && (op_d == OP_JAL))
         br_op_d = BR_OP_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FETCH;
         op_q        <= '0;
         func_q      <= '0;
         ir_write_q  <= 1'b0;
         pc_write_q  <= 1'b0;
         reg_write_q <= 2'b00;
         imm_mux_q   <= 1'b0;
         alu_mux_q   <= 1'b0;
         alu_op_q    <= '0;
         dmem_en_q   <= 1'b0;
         dmem_we_q   <= 1'b0;
         rwmux_q     <= 2'b00;
         br_op_q     <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         func_q      <= func_d;
         ir_write_q  <= ir_write_d;
         pc_write_q  <= pc_write_d;
         reg_write_q <= reg_write_d;
         imm_mux_q   <= imm_mux_d;
         alu_mux_q   <= alu_mux_d;
         alu_op_q    <= alu_op_d;
         dmem_en_q   <= dmem_en_d;
         dmem_we_q   <= dmem_we_d;
         rwmux_q     <= rwmux_d;
         br_op_q     <= br_op_d;
         halted_q    <= halted_d;
      end
   end

   assign bus.ir_write           = ir_write_q;
   assign bus.pc_write           = pc_write_q;
   assign bus.reg_write          = reg_write_q;
   assign bus.imm_mux_ctrl       = imm_mux_q;
   assign bus.alu_mux_ctrl       = alu_mux_q;
   assign bus.alu_op             = alu_op_q;
   assign bus.dmem_enable        = dmem_en_q;
   assign bus.dmem_write_enable  = dmem_we_q;
   assign bus.reg_write_mux_ctrl = rwmux_q;
   assign bus.br_op              = br_op_q;
   assign bus.halted             = halted_q;
endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: per-cycle expected control words are queued
// per instruction and popped against the DUT one cycle at a time.
module tb_control_fsm;
   typedef struct packed {
      logic       ir;
      logic       pc;
      logic [1:0] rw;
      logic       imm;
      logic       amux;
      logic [3:0] aop;
      logic       den;
      logic       dwe;
      logic [1:0] rwm;
      logic [4:0] br;
      logic       halt;
   } outs_t;

   logic clk = 1'b0;
   logic rst;
   outs_t expQ[$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   control_fsm_if #(.ALU_OP_W(4), .BR_OP_W(5)) bus ();
   control_fsm #(.ALU_OP_W(4), .BR_OP_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic outs_t observed();
      outs_t o;
      o.ir   = bus.ir_write;
      o.pc   = bus.pc_write;
      o.rw   = bus.reg_write;
      o.imm  = bus.imm_mux_ctrl;
      o.amux = bus.alu_mux_ctrl;
      o.aop  = bus.alu_op;
      o.den  = bus.dmem_enable;
      o.dwe  = bus.dmem_write_enable;
      o.rwm  = bus.reg_write_mux_ctrl;
      o.br   = bus.br_op;
      o.halt = bus.halted;
      return o;
   endfunction

   task automatic checkOutput(input string tag, input outs_t exp);
      outs_t obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference control words for one instruction, straight from the decode table.
   task automatic pushExpected(input logic [5:0] op, input logic [5:0] fn);
      outs_t f, z, e, m, w, h;
      f = '0; f.ir = 1'b1;
      z = '0;
      e = '0; m = '0; w = '0;
      h = '0; h.halt = 1'b1;
      expQ.push_back(f);
      expQ.push_back(z);
      case (op)
         6'b000000: begin
            if (fn > 6'd9) begin
               repeat (12) expQ.push_back(h);
            end else begin
               e.aop = fn[3:0];
               w = e; w.rw = 2'b01; w.rwm = 2'b10; w.pc = 1'b1;
               expQ.push_back(e); expQ.push_back(w);
            end
         end
         6'b000001: begin
            e.amux = 1'b1; e.imm = 1'b1;
            w = e; w.rw = 2'b01; w.rwm = 2'b10; w.pc = 1'b1;
            expQ.push_back(e); expQ.push_back(w);
         end
         6'b000010: begin
            e.amux = 1'b1; e.imm = 1'b1;
            m = e; m.den = 1'b1;
            w = e; w.rw = 2'b10; w.rwm = 2'b01; w.pc = 1'b1;
            expQ.push_back(e); expQ.push_back(m); expQ.push_back(w);
         end
         6'b000011: begin
            e.amux = 1'b1; e.imm = 1'b1;
            m = e; m.den = 1'b1; m.dwe = 1'b1; m.pc = 1'b1;
            expQ.push_back(e); expQ.push_back(m);
         end
         6'b000100: begin
            e.aop = 4'b0001; e.br = fn[4:0]; e.pc = 1'b1;
            expQ.push_back(e);
         end
         6'b000101: begin
            e.br = 5'b00001;
            w = e; w.rw = 2'b11; w.rwm = 2'b00; w.pc = 1'b1;
            expQ.push_back(e); expQ.push_back(w);
         end
         default: repeat (12) expQ.push_back(h);
      endcase
   endtask

   // Runs one instruction; abortAfter > 0 stops checking after that many cycles.
   task automatic applyStimulus(input string name, input logic [5:0] op,
                                input logic [5:0] fn, input int abortAfter);
      int k;
      outs_t e;
      bus.opcode = op;
      bus.func   = fn;
      pushExpected(op, fn);
      k = 0;
      while (expQ.size() > 0) begin
         @(posedge clk);
         #1;
         e = expQ.pop_front();
         checkOutput($sformatf("%s_c%0d", name, k), e);
         k++;
         if (k == 3) begin
            bus.opcode = 6'($urandom_range(0, 63));
            bus.func   = 6'($urandom_range(0, 63));
         end
         if (k == abortAfter) expQ.delete();
      end
   endtask

   // Asynchronous reset mid-cycle: outputs must clear before the next edge.
   task automatic doReset(input string name);
      #1 rst = 1'b1;
      #1 checkOutput({name, "_async"}, '0);
      repeat (2) @(posedge clk);
      #1 checkOutput({name, "_hold"}, '0);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.opcode = 6'b0;
      bus.func   = 6'b0;
      #40 checkOutput("reset", '0);
      #40 rst = 1'b0;

      applyStimulus("r_xor",  6'b000000, 6'b000011, 0);
      applyStimulus("addi",   6'b000001, 6'b101010, 0);
      applyStimulus("lw",     6'b000010, 6'b000000, 0);
      applyStimulus("sw",     6'b000011, 6'b000000, 0);
      applyStimulus("br",     6'b000100, 6'b000010, 0);
      applyStimulus("jal",    6'b000101, 6'b000000, 0);
      applyStimulus("r_f9",   6'b000000, 6'b001001, 0);
      applyStimulus("br_f1f", 6'b000100, 6'b111111, 0);

      applyStimulus("lw_abort", 6'b000010, 6'b000000, 4);
      doReset("rst_mem");
      applyStimulus("after_abort", 6'b000001, 6'b000000, 0);

      applyStimulus("illegal_op", 6'b001111, 6'b000000, 0);
      doReset("rst_ill");
      applyStimulus("illegal_func", 6'b000000, 6'b001100, 0);
      doReset("rst_func");
      applyStimulus("halt", 6'b111111, 6'b000000, 0);
      doReset("rst_halt");
      applyStimulus("final_r", 6'b000000, 6'b000000, 0);

      $display("[TB] done");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
